// File: rtl/my_ram1_pkg.sv
// Shared sizing and types for the my_ram1 single-port RAM.
package my_ram1_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/my_ram1_core.sv
// Storage array with write port and registered, write-through read port.
module my_ram1_core
    import my_ram1_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  we,
    input  addr_t addr,
    input  data_t wdata,
    output data_t rdata
);

    data_t mem_q [DEPTH] = '{default: '0};
    data_t rdata_d;
    data_t rdata_q = '0;

    // Same-edge write to the read address forwards the new word.
    always_comb begin
        rdata_d = mem_q[addr];
        if (we) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/my_ram1.sv
// 256x16 single-port synchronous RAM; define MY_RAM1_OUTREG_EN for an extra output stage.
module my_ram1
    import my_ram1_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  addr_t address,
    input  data_t data,
    input  logic  wren,
    output data_t q
);

    logic  wr_en;
    data_t core_q;

    always_comb begin
        wr_en = wren & ~reset;
    end

    my_ram1_core u_core (
        .clk   (clock),
        .clr   (reset),
        .we    (wr_en),
        .addr  (address),
        .wdata (data),
        .rdata (core_q)
    );

`ifdef MY_RAM1_OUTREG_EN
    data_t q_d;
    data_t q_q = '0;

    always_comb begin
        q_d = core_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
`else
    assign q = core_q;
`endif

endmodule

// File: tb/tb_my_ram1.sv
// Directed scoreboard bench for my_ram1; honours MY_RAM1_OUTREG_EN for read latency.
module tb_my_ram1;

`ifdef MY_RAM1_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  address = '0;
    logic [15:0] data = '0;
    logic        wren = 1'b0;
    logic [15:0] q;

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   started = 1'b0;
    int   step_id = 0;

    my_ram1 dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    always #10 clock = ~clock;

    // Drive one edge's inputs and queue the word q must show LAT edges later.
    task automatic step(input logic rst, input logic we, input logic [7:0] a,
                        input logic [15:0] d, input bit chk, input logic [15:0] e);
        @(negedge clock);
        #1;
        reset   = rst;
        wren    = we;
        address = a;
        data    = d;
        step_id++;
        exp_q.push_back('{chk: chk, exp: e, id: step_id});
        started = 1'b1;
    endtask

    // Monitor: each edge after stimulus starts yields one output word.
    initial begin : monitor
        int   n_edges;
        exp_t e;
        n_edges = 0;
        forever begin
            @(posedge clock);
            if (started) n_edges++;
            #1;
            if (n_edges >= LAT && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_cmp++;
                    if (q !== e.exp) begin
                        n_fail++;
                        $display("FAIL step%0d: q=%h expected=%h", e.id, q, e.exp);
                    end
                end
            end
        end
    end

    initial begin : stim
        int budget;
        // 1. reset, then read unwritten location
        step(1, 0, 8'h00, 16'h0000, 1, 16'h0000);
        step(1, 0, 8'h00, 16'h0000, 1, 16'h0000);
        step(0, 0, 8'h1A, 16'h0000, 1, 16'h0000);
        // 2. write then read back
        step(0, 1, 8'h1A, 16'h0021, 1, 16'h0021);
        step(0, 0, 8'h1A, 16'h0000, 1, 16'h0021);
        // 3. three writes, reverse readback
        step(0, 1, 8'h2B, 16'hBEEF, 1, 16'hBEEF);
        step(0, 1, 8'h3C, 16'h1234, 1, 16'h1234);
        step(0, 1, 8'h4D, 16'hFFFF, 1, 16'hFFFF);
        step(0, 0, 8'h4D, 16'h0000, 1, 16'hFFFF);
        step(0, 0, 8'h3C, 16'h0000, 1, 16'h1234);
        step(0, 0, 8'h2B, 16'h0000, 1, 16'hBEEF);
        step(0, 0, 8'h1A, 16'h0000, 1, 16'h0021);
        // 4. read-during-write returns new data
        step(0, 1, 8'h3C, 16'h5A5A, 1, 16'h5A5A);
        step(0, 0, 8'h3C, 16'h0000, 1, 16'h5A5A);
        // 5. address boundaries and neighbours
        step(0, 1, 8'h00, 16'h0001, 1, 16'h0001);
        step(0, 1, 8'hFF, 16'h8000, 1, 16'h8000);
        step(0, 0, 8'h00, 16'h0000, 1, 16'h0001);
        step(0, 0, 8'hFF, 16'h0000, 1, 16'h8000);
        step(0, 0, 8'h01, 16'h0000, 1, 16'h0000);
        step(0, 0, 8'hFE, 16'h0000, 1, 16'h0000);
        // 6. reset wins over write; memory retained
        step(0, 0, 8'h4D, 16'h0000, 0, 16'h0000);
        step(1, 1, 8'h4D, 16'h0000, 1, 16'h0000);
        step(0, 0, 8'h4D, 16'h0000, 1, 16'hFFFF);
        step(0, 0, 8'h1A, 16'h0000, 1, 16'h0021);

        @(negedge clock);
        #1;
        wren = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clock);
            #2;
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
